// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel servo/PWM generator.
// One shared period counter is advanced by a prescaler tick and compared
// against a double-buffered duty value per channel. Period and duty writes
// land in pending registers and are promoted to the active set only at a
// period boundary, so a pulse is never cut short or stretched.
//
// Ports:
//   clk     system clock
//   rst     asynchronous reset, active-high
//   en      run enable; low freezes counter/prescaler and forces outputs low
//   load    one-cycle write strobe (accepted regardless of en)
//   sel     channel write mask, one bit per channel
//   period  new period in ticks, written on load
//   duty    new high time in ticks, written to every selected channel
//   out     registered PWM outputs
//   frame   registered one-clk pulse at each period start
//
// Build option:
//   PWM_CENTER_ALIGNED_EN  up/down counter, frame of 2*period ticks with the
//                          pulse centred on the frame start. Undefined gives
//                          the edge-aligned up-counter.
module pwm_multi #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned DIV      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [CHANNELS-1:0] sel,
  input  logic [CNT_W-1:0]    period,
  input  logic [CNT_W-1:0]    duty,
  output logic [CHANNELS-1:0] out,
  output logic                frame
);

  localparam int unsigned      PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0]               pre_q, pre_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [CNT_W-1:0]               per_pend_q, per_pend_d;
  logic [CNT_W-1:0]               per_act_q, per_act_d;
  logic [CHANNELS-1:0][CNT_W-1:0] duty_pend_q, duty_pend_d;
  logic [CHANNELS-1:0][CNT_W-1:0] duty_act_q, duty_act_d;
  logic [CHANNELS-1:0]            out_d;
  logic                           frame_d;
  logic                           tick_c;
  logic                           bnd_c;
  logic [CNT_W-1:0]               cnt_last_c;
`ifdef PWM_CENTER_ALIGNED_EN
  logic                           down_q, down_d;
`endif

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q       <= '0;
      cnt_q       <= '0;
      per_pend_q  <= '0;
      per_act_q   <= '0;
      duty_pend_q <= '0;
      duty_act_q  <= '0;
      out         <= '0;
      frame       <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      down_q      <= 1'b0;
`endif
    end else begin
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      per_pend_q  <= per_pend_d;
      per_act_q   <= per_act_d;
      duty_pend_q <= duty_pend_d;
      duty_act_q  <= duty_act_d;
      out         <= out_d;
      frame       <= frame_d;
`ifdef PWM_CENTER_ALIGNED_EN
      down_q      <= down_d;
`endif
    end
  end

  // Prescaler: one tick every DIV enabled clocks
  always_comb begin
    tick_c = en && (pre_q == PRE_LAST);
    pre_d  = pre_q;
    if (en) begin
      pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
    end
  end

  // Host writes go to the pending set only
  always_comb begin
    per_pend_d  = load ? period : per_pend_q;
    duty_pend_d = duty_pend_q;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (load && sel[i]) begin
        duty_pend_d[i] = duty;
      end
    end
  end

  // Period counter and promotion of pending values at the boundary
  always_comb begin
    cnt_last_c = per_act_q - CNT_W'(1);
    cnt_d      = cnt_q;
    per_act_d  = per_act_q;
    duty_act_d = duty_act_q;
    bnd_c      = 1'b0;
    frame_d    = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
    down_d     = down_q;
`endif
    if (tick_c) begin
      if (per_act_q == '0) begin
        // Idle: pick up whatever has been programmed, no frame pulse
        cnt_d      = '0;
        per_act_d  = per_pend_q;
        duty_act_d = duty_pend_q;
      end else begin
`ifdef PWM_CENTER_ALIGNED_EN
        if (!down_q) begin
          // top value is held for a second tick on the way down
          if (cnt_q == cnt_last_c) begin
            down_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (cnt_q == '0) begin
          // bottom turnaround: 0 was already shown once going down
          down_d = 1'b0;
          bnd_c  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`else
        if (cnt_q == cnt_last_c) begin
          cnt_d = '0;
          bnd_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
        if (bnd_c) begin
          per_act_d  = per_pend_q;
          duty_act_d = duty_pend_q;
          frame_d    = 1'b1;
        end
      end
    end
  end

  // Outputs use next-state values so they move on the same edge as cnt
  always_comb begin
    out_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      out_d[i] = en && (per_act_d != '0) && (duty_act_d[i] > cnt_d);
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: two instances (DIV=1 and DIV=4) share the
// same stimulus; a cycle model pushes expected out/frame per edge and the
// sampled DUT values are popped and compared, plus directed pulse counts.
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [7:0] sel;
  logic [4:0] period, duty;
  logic [7:0] out1, out4;
  logic       frame1, frame4;

  always #5 clk = ~clk;

  pwm_multi #(.CHANNELS(8), .CNT_W(5), .DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .sel(sel),
    .period(period), .duty(duty), .out(out1), .frame(frame1)
  );

  pwm_multi #(.CHANNELS(8), .CNT_W(5), .DIV(4)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .load(load), .sel(sel),
    .period(period), .duty(duty), .out(out4), .frame(frame4)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [17:0] sb_q[$];

  // Reference state per instance
  int m_pre[2], m_cnt[2], m_per[2], m_pper[2];
  int m_duty[2][8], m_pduty[2][8];

  logic [7:0] obs_out[2];
  logic       obs_fr[2];
  int         hi[2][8];
  int         fr[2];
  int         cyc;
  int         inph;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Advance the reference by one clock using the inputs currently driven
  task automatic model_step();
    logic [17:0] e;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      int         dv;
      bit         tick;
      bit         bnd;
      logic [7:0] o;
      dv  = (k == 0) ? 1 : 4;
      o   = '0;
      bnd = 1'b0;
      if (rst) begin
        m_pre[k] = 0; m_cnt[k] = 0; m_per[k] = 0; m_pper[k] = 0;
        for (int i = 0; i < 8; i++) begin
          m_duty[k][i]  = 0;
          m_pduty[k][i] = 0;
        end
      end else begin
        tick = en && (m_pre[k] == dv - 1);
        if (en) m_pre[k] = tick ? 0 : m_pre[k] + 1;
        if (tick) begin
          if (m_per[k] != 0 && m_cnt[k] < m_per[k] - 1) begin
            m_cnt[k]++;
          end else begin
            bnd      = (m_per[k] != 0);
            m_cnt[k] = 0;
            m_per[k] = m_pper[k];
            for (int i = 0; i < 8; i++) m_duty[k][i] = m_pduty[k][i];
          end
        end
        if (load) begin
          m_pper[k] = int'(period);
          for (int i = 0; i < 8; i++) if (sel[i]) m_pduty[k][i] = int'(duty);
        end
        if (en && m_per[k] != 0)
          for (int i = 0; i < 8; i++) o[i] = (m_duty[k][i] > m_cnt[k]);
      end
      e[k*9 +: 9] = {bnd, o};
    end
    sb_q.push_back(e);
  endtask

  // One clock: predict, clock, sample away from the edge, compare
  task automatic cycle();
    logic [17:0] e;
    model_step();
    @(posedge clk);
    #1;
    obs_out[0] = out1;
    obs_out[1] = out4;
    obs_fr[0]  = frame1;
    obs_fr[1]  = frame4;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("out_div1",   32'(out1),   32'(e[7:0]));
      chk("frame_div1", 32'(frame1), 32'(e[8]));
      chk("out_div4",   32'(out4),   32'(e[16:9]));
      chk("frame_div4", 32'(frame4), 32'(e[17]));
    end
  endtask

  task automatic clear();
    cyc  = 0;
    inph = 0;
    for (int k = 0; k < 2; k++) begin
      fr[k] = 0;
      for (int i = 0; i < 8; i++) hi[k][i] = 0;
    end
  endtask

  task automatic acc();
    cyc++;
    for (int k = 0; k < 2; k++) begin
      fr[k] += int'(obs_fr[k]);
      for (int i = 0; i < 8; i++) hi[k][i] += int'(obs_out[k][i]);
    end
    if (obs_out[1][2] == obs_out[1][5]) inph++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      cycle();
      acc();
    end
  endtask

  task automatic do_load(input logic [7:0] s, input logic [4:0] p, input logic [4:0] d);
    sel    = s;
    period = p;
    duty   = d;
    load   = 1'b1;
    run(1);
    load   = 1'b0;
    sel    = '0;
  endtask

  task automatic wait_frame(input int k, input int budget);
    int t = 0;
    do begin
      cycle();
      t++;
    end while (!obs_fr[k] && t < budget);
    if (!obs_fr[k]) chk("wait_frame_timeout", 32'(obs_fr[k]), 32'd1);
  endtask

  // Accumulate samples until the next frame pulse of instance k (not counted)
  task automatic acc_to_frame(input int k);
    int t    = 0;
    bit done = 1'b0;
    while (!done && t < 200) begin
      cycle();
      t++;
      if (obs_fr[k]) done = 1'b1;
      else acc();
    end
    if (!done) chk("frame_timeout", 32'(obs_fr[k]), 32'd1);
  endtask

  // Called on a frame sample: counts exactly one period of instance k
  task automatic measure_frame(input int k);
    acc();
    acc_to_frame(k);
  endtask

  function automatic int hsum(input int k);
    int s = 0;
    for (int i = 0; i < 8; i++) s += hi[k][i];
    return s;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; sel = '0; period = '0; duty = '0;

    // Reset with random inputs, then idle until the first load
    repeat (3) begin
      en     = 1'($urandom);
      load   = 1'($urandom);
      sel    = 8'($urandom);
      period = 5'($urandom);
      duty   = 5'($urandom);
      cycle();
    end
    rst = 1'b0; en = 1'b1; load = 1'b0; sel = '0; period = '0; duty = '0;
    clear();
    run(10);
    chk("reset_out",   32'(hsum(0) + hsum(1)), 32'd0);
    chk("reset_frame", 32'(fr[0] + fr[1]),     32'd0);

    // Basic: ch0 duty 2 of 20
    do_load(8'h01, 5'd20, 5'd2);
    wait_frame(0, 60);
    chk("basic_rise", 32'(obs_out[0][0]), 32'd1);
    clear();
    measure_frame(0);
    chk("basic_len",    32'(cyc),                32'd20);
    chk("basic_hi0",    32'(hi[0][0]),           32'd2);
    chk("basic_others", 32'(hsum(0) - hi[0][0]), 32'd0);
    chk("basic_frames", 32'(fr[0]),              32'd1);
    chk("basic_rise2",  32'(obs_out[0][0]),      32'd1);

    // Extremes: duty 0 and duty above period
    do_load(8'h02, 5'd20, 5'd0);
    do_load(8'h04, 5'd20, 5'd25);
    wait_frame(0, 60);
    clear();
    repeat (5) measure_frame(0);
    chk("ext_len",  32'(cyc),      32'd100);
    chk("ext_hi1",  32'(hi[0][1]), 32'd0);
    chk("ext_hi2",  32'(hi[0][2]), 32'd100);
    chk("ext_hi0",  32'(hi[0][0]), 32'd10);
    chk("ext_frms", 32'(fr[0]),    32'd5);

    // Double buffer: mid-period write, then write on the boundary edge
    do_load(8'h08, 5'd20, 5'd7);
    wait_frame(0, 60);
    clear();
    acc();
    run(5);
    do_load(8'h08, 5'd20, 5'd3);
    acc_to_frame(0);
    chk("dbuf_cur",  32'(hi[0][3]), 32'd7);
    chk("dbuf_len",  32'(cyc),      32'd20);
    clear();
    measure_frame(0);
    chk("dbuf_next", 32'(hi[0][3]), 32'd3);
    run(19);
    do_load(8'h08, 5'd20, 5'd9);
    chk("bnd_frame", 32'(obs_fr[0]), 32'd1);
    clear();
    measure_frame(0);
    chk("bnd_old", 32'(hi[0][3]), 32'd3);
    clear();
    measure_frame(0);
    chk("bnd_new", 32'(hi[0][3]), 32'd9);

    // Multi-select with DIV=4 instance
    do_load(8'h24, 5'd10, 5'd8);
    wait_frame(1, 200);
    wait_frame(1, 200);
    clear();
    measure_frame(1);
    chk("div4_len",   32'(cyc),      32'd40);
    chk("div4_hi2",   32'(hi[1][2]), 32'd32);
    chk("div4_hi5",   32'(hi[1][5]), 32'd32);
    chk("div4_phase", 32'(inph),     32'd40);

    // Enable pause mid-period, then reset mid-period
    wait_frame(0, 50);
    run(3);
    en = 1'b0;
    clear();
    run(7);
    chk("en_low",    32'(hsum(0) + hsum(1)), 32'd0);
    chk("en_frames", 32'(fr[0] + fr[1]),     32'd0);
    en = 1'b1;
    clear();
    acc_to_frame(0);
    chk("resume_len", 32'(cyc),      32'd6);
    chk("resume_hi2", 32'(hi[0][2]), 32'd4);
    run(4);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    clear();
    run(60);
    chk("post_rst_out",   32'(hsum(0) + hsum(1)), 32'd0);
    chk("post_rst_frame", 32'(fr[0] + fr[1]),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
